// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    localparam logic [4:0] XZR          = 5'd31;
    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

    // A load into the zero register never creates a real dependency.
    function automatic logic load_use(input logic       mem_read,
                                      input logic [4:0] rd,
                                      input logic [4:0] rn,
                                      input logic [4:0] rm);
        return mem_read && (rd != XZR) && ((rd == rn) || (rd == rm));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller; master = pipeline, slave = controller.
interface hazard_ctrl_if #(
    parameter int CW = 16
);
    logic [4:0]    rn_D;
    logic [4:0]    rm_D;
    logic          halt_D;
    logic          memRead_E;
    logic [4:0]    rd_E;
    logic          branchTaken_M;
    logic          pcWrite;
    logic          ifidWrite;
    logic          flush_D;
    logic          flush_E;
    logic          flush_M;
    logic          pcSrc;
    logic          halted;
    logic [CW-1:0] stallCount;
    logic [CW-1:0] flushCount;

    modport master (
        output rn_D, rm_D, halt_D, memRead_E, rd_E, branchTaken_M,
        input  pcWrite, ifidWrite, flush_D, flush_E, flush_M, pcSrc, halted,
               stallCount, flushCount
    );

    modport slave (
        input  rn_D, rm_D, halt_D, memRead_E, rd_E, branchTaken_M,
        output pcWrite, ifidWrite, flush_D, flush_E, flush_M, pcSrc, halted,
               stallCount, flushCount
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/halt controller for a five-stage pipeline; control outputs are
// combinational from state and inputs, state and counters are registered.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus,
    output hz_state_t     state_dbg
);
    hz_state_t  state, state_nxt;
    logic [1:0] drain_cnt, drain_nxt;
    logic       lu, br;
    logic       stall_ev, flush_ev;
    logic       pc_write, ifid_write, fl_d, fl_e, fl_m, pc_src, halted_o;

    assign lu = load_use(bus.memRead_E, bus.rd_E, bus.rn_D, bus.rm_D);
    assign br = bus.branchTaken_M;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            RUN: begin
                if (br) begin
                    drain_nxt = 2'd0;
                end else if (!lu && bus.halt_D) begin
                    state_nxt = DRAIN;
                    drain_nxt = DRAIN_CYCLES;
                end
            end
            DRAIN: begin
                // A taken branch means the halt was fetched down the wrong path.
                if (br) begin
                    state_nxt = RUN;
                    drain_nxt = 2'd0;
                end else begin
                    drain_nxt = drain_cnt - 2'd1;
                    if (drain_cnt == 2'd1) state_nxt = HALTED;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = RUN;
                drain_nxt = 2'd0;
            end
        endcase
    end

    // Reset presents the free-running RUN outputs regardless of inputs.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        fl_d       = 1'b0;
        fl_e       = 1'b0;
        fl_m       = 1'b0;
        pc_src     = 1'b0;
        halted_o   = 1'b0;
        stall_ev   = 1'b0;
        flush_ev   = 1'b0;
        if (reset) begin
            case (state)
                RUN, DRAIN: begin
                    if (br) begin
                        pc_src   = 1'b1;
                        fl_d     = 1'b1;
                        fl_e     = 1'b1;
                        fl_m     = 1'b1;
                        flush_ev = 1'b1;
                    end else if (state == RUN && lu) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        fl_e       = 1'b1;
                        stall_ev   = 1'b1;
                    end else if (state == DRAIN || bus.halt_D) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        fl_d       = 1'b1;
                    end
                end
                HALTED: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    fl_d       = 1'b1;
                    fl_e       = 1'b1;
                    fl_m       = 1'b1;
                    halted_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pcWrite   = pc_write;
    assign bus.ifidWrite = ifid_write;
    assign bus.flush_D   = fl_d;
    assign bus.flush_E   = fl_e;
    assign bus.flush_M   = fl_m;
    assign bus.pcSrc     = pc_src;
    assign bus.halted    = halted_o;
    assign state_dbg     = state;

    sat_counter #(.W(CW)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_ev),
        .count (bus.stallCount)
    );

    sat_counter #(.W(CW)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_ev),
        .count (bus.flushCount)
    );
endmodule
